// File: rtl/camera_power_seq.sv
// Camera sensor power-up sequencer: qualifies the synchronised PLL lock, then walks
// the sensor through power-down, reset and settle before launching SCCB init.
//
// state     | meaning
// WAIT_LOCK | sensor held off, waiting for synchronised lock
// STABLE    | lock seen, counting qualification interval
// PWDN      | XCLK running, sensor still powered down
// RESET     | power-down released, reset held
// SETTLE    | reset released, waiting for sensor to settle
// READY     | sequence complete, SCCB init launched on entry
module camera_power_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_STABLE = 1024,
    parameter int T_PWDN      = 50000,
    parameter int T_RST       = 50000,
    parameter int T_SETTLE    = 1000000,
    parameter int CNT_W       = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       xclk_en,
    output logic       init_start,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] relock_cnt
);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_PWDN,
        ST_RESET,
        ST_SETTLE,
        ST_READY
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] PWDN_LAST   = CNT_W'(T_PWDN - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(T_RST - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(T_SETTLE - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   cam_pwdn_q, cam_pwdn_d;
    logic                   cam_rst_n_q, cam_rst_n_d;
    logic                   xclk_en_q, xclk_en_d;
    logic                   init_start_q, init_start_d;
    logic                   ready_q, ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [7:0]             relock_cnt_q, relock_cnt_d;
    logic                   lock_s;
    logic                   lock_loss;
    logic                   counting;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pll_lock};
    end

    // Next-state; a lock loss overrides restart and any phase-complete transition.
    always_comb begin
        state_d   = state_q;
        lock_loss = 1'b0;
        counting  = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) state_d = ST_STABLE;
            end
            ST_STABLE: begin
                counting = 1'b1;
                if (!lock_s)                   state_d = ST_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = ST_PWDN;
            end
            ST_PWDN: begin
                counting = 1'b1;
                if (cnt_q == PWDN_LAST) state_d = ST_RESET;
            end
            ST_RESET: begin
                counting = 1'b1;
                if (cnt_q == RST_LAST) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                counting = 1'b1;
                if (cnt_q == SETTLE_LAST) state_d = ST_READY;
            end
            ST_READY: begin
                if (restart) state_d = ST_PWDN;
            end
            default: state_d = ST_WAIT_LOCK;
        endcase

        if (!lock_s && (state_q == ST_PWDN || state_q == ST_RESET ||
                        state_q == ST_SETTLE || state_q == ST_READY)) begin
            lock_loss = 1'b1;
            state_d   = ST_WAIT_LOCK;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) cnt_d = '0;
        else if (counting)      cnt_d = cnt_q + 1'b1;
    end

    // Outputs decoded from the next state so they move on the same edge as the state.
    always_comb begin
        cam_pwdn_d   = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) ||
                       (state_d == ST_PWDN);
        cam_rst_n_d  = (state_d == ST_SETTLE) || (state_d == ST_READY);
        xclk_en_d    = (state_d != ST_WAIT_LOCK) && (state_d != ST_STABLE);
        ready_d      = (state_d == ST_READY);
        init_start_d = (state_d == ST_READY) && (state_q != ST_READY);
        lock_lost_d  = lock_lost_q | lock_loss;
        relock_cnt_d = relock_cnt_q;
        if (lock_loss && relock_cnt_q != 8'hFF) relock_cnt_d = relock_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            sync_q       <= '0;
            cam_pwdn_q   <= 1'b1;
            cam_rst_n_q  <= 1'b0;
            xclk_en_q    <= 1'b0;
            init_start_q <= 1'b0;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
            relock_cnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync_q       <= sync_d;
            cam_pwdn_q   <= cam_pwdn_d;
            cam_rst_n_q  <= cam_rst_n_d;
            xclk_en_q    <= xclk_en_d;
            init_start_q <= init_start_d;
            ready_q      <= ready_d;
            lock_lost_q  <= lock_lost_d;
            relock_cnt_q <= relock_cnt_d;
        end
    end

    assign cam_pwdn   = cam_pwdn_q;
    assign cam_rst_n  = cam_rst_n_q;
    assign xclk_en    = xclk_en_q;
    assign init_start = init_start_q;
    assign ready      = ready_q;
    assign lock_lost  = lock_lost_q;
    assign relock_cnt = relock_cnt_q;

endmodule

// File: tb/tb_camera_power_seq.sv
// Bench for camera_power_seq: expected output snapshots are queued per cycle as
// stimulus is applied and compared when that cycle's outputs are sampled.
module tb_camera_power_seq;

    localparam int SYNC = 2;
    localparam int LS   = 4;
    localparam int TP   = 8;
    localparam int TR   = 6;
    localparam int TS   = 10;

    localparam int T_XCLK = SYNC + 1 + LS;
    localparam int T_PEND = T_XCLK + TP;
    localparam int T_RSTN = T_PEND + TR;
    localparam int T_RDY  = T_RSTN + TS;

    // {cam_pwdn, cam_rst_n, xclk_en}
    localparam logic [2:0] PH_OFF  = 3'b100;
    localparam logic [2:0] PH_PWDN = 3'b101;
    localparam logic [2:0] PH_RST  = 3'b001;
    localparam logic [2:0] PH_RUN  = 3'b011;

    logic       clk = 1'b0;
    logic       reset, pll_lock, restart;
    logic       cam_pwdn, cam_rst_n, xclk_en, init_start, ready, lock_lost;
    logic [7:0] relock_cnt;
    logic [13:0] obs;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          cyc;
        string       tag;
        logic [13:0] v;
    } exp_t;

    exp_t sb[$];

    camera_power_seq #(
        .SYNC_STAGES(SYNC), .LOCK_STABLE(LS), .T_PWDN(TP), .T_RST(TR),
        .T_SETTLE(TS), .CNT_W(24)
    ) dut (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .restart(restart),
        .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n), .xclk_en(xclk_en),
        .init_start(init_start), .ready(ready), .lock_lost(lock_lost),
        .relock_cnt(relock_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign obs = {cam_pwdn, cam_rst_n, xclk_en, init_start, ready, lock_lost, relock_cnt};

    function automatic logic [13:0] ov(logic [2:0] ph, logic ini, logic rdy,
                                       logic lost, logic [7:0] rc);
        return {ph, ini, rdy, lost, rc};
    endfunction

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic push(int c, string tag, logic [13:0] v);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full power-up sequence expectations with pll_lock raised just after edge c0.
    task automatic push_seq(int c0, logic lost, logic [7:0] rc, string tag);
        push(c0 + T_XCLK - 1, {tag, "_off"},     ov(PH_OFF,  1'b0, 1'b0, lost, rc));
        push(c0 + T_XCLK,     {tag, "_xclk"},    ov(PH_PWDN, 1'b0, 1'b0, lost, rc));
        push(c0 + T_PEND - 1, {tag, "_pwdn"},    ov(PH_PWDN, 1'b0, 1'b0, lost, rc));
        push(c0 + T_PEND,     {tag, "_rst"},     ov(PH_RST,  1'b0, 1'b0, lost, rc));
        push(c0 + T_RSTN - 1, {tag, "_rst_end"}, ov(PH_RST,  1'b0, 1'b0, lost, rc));
        push(c0 + T_RSTN,     {tag, "_settle"},  ov(PH_RUN,  1'b0, 1'b0, lost, rc));
        push(c0 + T_RDY - 1,  {tag, "_prerdy"},  ov(PH_RUN,  1'b0, 1'b0, lost, rc));
        push(c0 + T_RDY,      {tag, "_ready"},   ov(PH_RUN,  1'b1, 1'b1, lost, rc));
        push(c0 + T_RDY + 1,  {tag, "_hold"},    ov(PH_RUN,  1'b0, 1'b1, lost, rc));
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check_val($sformatf("%s@%0d", sb[i].tag, cyc), {18'b0, obs}, {18'b0, sb[i].v});
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: cycle %0d reached time limit", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, c3, c4, r, d, t, rc_exp;

        reset = 1'b1; pll_lock = 1'b0; restart = 1'b0;
        tick(3);
        push(cyc, "reset_state", ov(PH_OFF, 1'b0, 1'b0, 1'b0, 8'd0));
        tick(1);

        // Scenario 1: clean power-up
        reset = 1'b0; pll_lock = 1'b1;
        c0 = cyc;
        push_seq(c0, 1'b0, 8'd0, "s1");
        tick(T_RDY + 3);

        // Scenario 2: glitch during STABLE restarts qualification
        reset = 1'b1; pll_lock = 1'b0;
        tick(2);
        reset = 1'b0; pll_lock = 1'b1;
        c0 = cyc;
        tick(3);
        pll_lock = 1'b0;
        push(c0 + 5, "s2_stable", ov(PH_OFF, 1'b0, 1'b0, 1'b0, 8'd0));
        push(c0 + 6, "s2_wait",   ov(PH_OFF, 1'b0, 1'b0, 1'b0, 8'd0));
        tick(3);
        pll_lock = 1'b1;
        c1 = cyc;
        push(c0 + T_RDY, "s2_delayed", ov(PH_RUN, 1'b0, 1'b0, 1'b0, 8'd0));
        push_seq(c1, 1'b0, 8'd0, "s2");
        tick(T_RDY + 3);

        // Scenario 3: lock drop during SETTLE, then relock
        reset = 1'b1; pll_lock = 1'b0;
        tick(2);
        reset = 1'b0; pll_lock = 1'b1;
        c0 = cyc;
        push(c0 + T_XCLK, "s3_xclk",   ov(PH_PWDN, 1'b0, 1'b0, 1'b0, 8'd0));
        push(c0 + T_RSTN, "s3_settle", ov(PH_RUN,  1'b0, 1'b0, 1'b0, 8'd0));
        tick(25);
        pll_lock = 1'b0;
        push(c0 + 27, "s3_seen", ov(PH_RUN, 1'b0, 1'b0, 1'b0, 8'd0));
        push(c0 + 28, "s3_loss", ov(PH_OFF, 1'b0, 1'b0, 1'b1, 8'd1));
        tick(5);
        pll_lock = 1'b1;
        c2 = cyc;
        push_seq(c2, 1'b1, 8'd1, "s3");

        // Scenario 4: restart during SETTLE ignored, restart in READY honoured
        tick(25);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        push(c2 + T_RDY + 2, "s4_noqueue", ov(PH_RUN, 1'b0, 1'b1, 1'b1, 8'd1));
        tick(9);
        r = cyc;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        push(r + 1,       "s4_pwdn",   ov(PH_PWDN, 1'b0, 1'b0, 1'b1, 8'd1));
        push(r + TP,      "s4_pend",   ov(PH_PWDN, 1'b0, 1'b0, 1'b1, 8'd1));
        push(r + 1 + TP,  "s4_rst",    ov(PH_RST,  1'b0, 1'b0, 1'b1, 8'd1));
        push(r + 24,      "s4_prerdy", ov(PH_RUN,  1'b0, 1'b0, 1'b1, 8'd1));
        push(r + 25,      "s4_init",   ov(PH_RUN,  1'b1, 1'b1, 1'b1, 8'd1));
        push(r + 26,      "s4_hold",   ov(PH_RUN,  1'b0, 1'b1, 1'b1, 8'd1));
        tick(28);

        // Scenario 5: lock loss and restart in the same READY cycle
        d = cyc;
        pll_lock = 1'b0;
        tick(2);
        restart = 1'b1;
        push(d + 2, "s5_pre",    ov(PH_RUN, 1'b0, 1'b1, 1'b1, 8'd1));
        push(d + 3, "s5_loss",   ov(PH_OFF, 1'b0, 1'b0, 1'b1, 8'd2));
        push(d + 5, "s5_nopwdn", ov(PH_OFF, 1'b0, 1'b0, 1'b1, 8'd2));
        tick(1);
        restart = 1'b0;
        tick(3);

        for (int k = 1; k <= 300; k++) begin
            pll_lock = 1'b1;
            tick(8);
            pll_lock = 1'b0;
            t = cyc;
            rc_exp = (2 + k > 255) ? 255 : 2 + k;
            push(t + 3, $sformatf("s5_sat%0d", k), ov(PH_OFF, 1'b0, 1'b0, 1'b1, 8'(rc_exp)));
            tick(4);
        end

        // Scenario 6: reset during RESET phase with lock held high
        pll_lock = 1'b1;
        c3 = cyc;
        push(c3 + 17, "s6_pre", ov(PH_RST, 1'b0, 1'b0, 1'b1, 8'd255));
        tick(17);
        reset = 1'b1;
        push(c3 + 18, "s6_rst", ov(PH_OFF, 1'b0, 1'b0, 1'b0, 8'd0));
        tick(2);
        reset = 1'b0;
        c4 = cyc;
        push_seq(c4, 1'b0, 8'd0, "s6");
        tick(T_RDY + 3);

        tick(2);
        check_val("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
